ram_port_ctrl: RTL and testbench
================================

# ram_port_ctrl

Arbiter and sequencer for the single-port 8-word × 8-bit convolution scratch RAM. It shares the RAM's one port between a write requester (pixel/kernel loader) and a read requester (convolution engine). Each cycle it grants at most one access, drives the RAM's wr/address/din, and returns read data with a valid strobe that matches the RAM's one-cycle registered read latency. It sits between the loader, the convolution datapath and the RAM instance, and also tracks which words hold loaded data.

## Interface
Parameters:
- WORDS, 8, RAM depth in words; power of two
- AW, 3, address width; log2(WORDS)
- DW, 8, data width
- RR_EN, 1, 1 = round-robin on conflict; 0 = fixed priority, read wins

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  reset; asynchronous, active-low
- wr_valid  in  1  write request
- wr_ready  out  1  write granted this cycle
- wr_addr  in  AW  write address
- wr_data  in  DW  write data
- rd_valid  in  1  read request
- rd_ready  out  1  read granted this cycle
- rd_addr  in  AW  read address
- rd_data  out  DW  read data; meaningful only while rd_rvalid=1
- rd_rvalid  out  1  read data valid; one cycle after the read grant
- rd_hit  out  1  qualifies rd_data; 1 = the word was written since the last clear
- clr  in  1  clears the written mask; RAM contents are untouched
- word_written  out  WORDS  per-word written mask
- ram_wr  out  1  to the RAM's wr input; 1 = write
- ram_addr  out  AW  to the RAM's address input
- ram_din  out  DW  to the RAM's din input
- ram_dout  in  DW  from the RAM's registered dout

## Operation
- Grant logic is combinational from the valids and the `last_win` register. A transfer happens when valid && ready.
- Only wr_valid: grant write. Only rd_valid: grant read. Neither: idle.
- Both valid, RR_EN=1: grant the side opposite `last_win`, then update `last_win`. `last_win` resets to WRITE, so the first conflict goes to read.
- Both valid, RR_EN=0: read always wins. `last_win` is unused.
- `last_win` is updated only in conflict cycles.
- Write grant: ram_wr=1, ram_addr=wr_addr, ram_din=wr_data. Sets word_written[wr_addr].
- Read grant: ram_wr=0, ram_addr=rd_addr, ram_din=0.
- Idle: ram_wr=0, ram_addr=0, ram_din=0. The RAM performs a harmless read of word 0.
- Read pipeline: on a read grant in cycle N, register rvalid_q=1 and hit_q=word_written[rd_addr]. In cycle N+1:
  - rd_rvalid = rvalid_q
  - rd_data = ram_dout when rvalid_q=1, otherwise 0
  - rd_hit = hit_q
- Back-to-back reads produce one rd_rvalid pulse per grant, with no bubble.
- Write-then-read to the same address in consecutive cycles returns the new data. The RAM updates at the write edge, so no bypass is needed.
- clr and a write grant in the same cycle: the clear applies first, so only the newly written bit is set afterwards.
- A read granted in the same cycle as clr samples the mask before the clear.
- Requesters may hold valid high across cycles. Address and data must stay stable until ready is seen.
- Reset, including mid-operation: rvalid_q=0, hit_q=0, word_written=0, last_win=WRITE.
  - Outputs while in reset: wr_ready=0, rd_ready=0, rd_rvalid=0, rd_data=0, rd_hit=0, ram_wr=0, ram_addr=0, ram_din=0.
  - Any read in flight is dropped: no rd_rvalid after reset release.

## Timing
- Grant latency is 0: ready is asserted in the same cycle as valid when the side wins.
- Read data latency is exactly 1 cycle from the grant edge.
- Throughput is one access per cycle, either read or write.
- Worst-case wait under continuous contention with RR_EN=1 is 1 cycle.
- With RR_EN=0, the write side can starve. That is acceptable by design because the loader finishes before convolution starts.
- Combinational paths: valids → ready, ram_*; ram_dout → rd_data. No path from inputs to `last_win` bypasses a register.

## Structure
- Shared package `conv_pkg`:
  - RAM_WORDS=8, RAM_AW=3, RAM_DW=8
  - enum `grant_t` {GNT_NONE, GNT_WR, GNT_RD}
  - `last_win` encoding
- One sub-module, `rr_arb2`: the two-requester arbiter (inputs: req pair, rr_en; outputs: grant_t; holds the `last_win` register).
- The RAM stays outside this block and is connected at the level above.

## Test plan
- Reset then load: write 0x11..0x88 to addresses 0..7 with rd_valid=0 → wr_ready=1 every cycle; word_written goes 0x01,0x03,…,0xFF.
- Read-back: read addresses 7..0 back-to-back → rd_rvalid high for 8 consecutive cycles, each one cycle after its grant; rd_data=0x88..0x11; rd_hit=1.
- Contention with RR_EN=1: both valid for 4 cycles → grants in order RD, WR, RD, WR. With RR_EN=0 → RD for all 4 cycles; wr_ready=0.
- Write 0x5A to address 3, then read address 3 in the next cycle → rd_data=0x5A at grant+1.
- Clear: pulse clr, then read address 2 → rd_rvalid=1, rd_hit=0. Simultaneous clr and write to address 4 → word_written=0x10.
- Reset mid-read: assert rst_n=0 in the grant cycle → no rd_rvalid afterwards; all outputs 0; word_written=0.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution scratch RAM and its port controller.
package conv_pkg;

  localparam int RAM_WORDS = 8;
  localparam int RAM_AW    = 3;
  localparam int RAM_DW    = 8;

  // Which side, if any, owns the RAM port in the current cycle.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WR   = 2'd1,
    GNT_RD   = 2'd2
  } grant_t;

  // Winner of the most recent conflict cycle.
  typedef enum logic {
    WIN_WR = 1'b0,
    WIN_RD = 1'b1
  } last_win_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester arbiter for the RAM port: write vs read.
// Conflicts alternate when rr_en=1 (starting with read); otherwise read wins.
module rr_arb2
  import conv_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   wr_req,
  input  logic   rd_req,
  input  logic   rr_en,
  output grant_t grant
);

  last_win_t last_win_q;
  last_win_t last_win_d;

  // Grant decode and next conflict winner; last_win moves only on conflicts.
  always_comb begin
    grant      = GNT_NONE;
    last_win_d = last_win_q;
    case ({wr_req, rd_req})
      2'b10: grant = GNT_WR;
      2'b01: grant = GNT_RD;
      2'b11: begin
        if (rr_en) begin
          if (last_win_q == WIN_WR) begin
            grant      = GNT_RD;
            last_win_d = WIN_RD;
          end else begin
            grant      = GNT_WR;
            last_win_d = WIN_WR;
          end
        end else begin
          grant = GNT_RD;
        end
      end
      default: grant = GNT_NONE;
    endcase
  end

  // Conflict-history register; reset makes the first conflict go to read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_win_q <= WIN_WR;
    end else begin
      last_win_q <= last_win_d;
    end
  end

endmodule

// File: rtl/ram_port_ctrl.sv
// Port sequencer for the single-port convolution scratch RAM.
// Arbitrates loader writes against engine reads, drives the RAM port,
// returns read data one cycle after the grant and tracks written words.
module ram_port_ctrl
  import conv_pkg::*;
#(
  parameter int WORDS = RAM_WORDS,
  parameter int AW    = RAM_AW,
  parameter int DW    = RAM_DW,
  parameter int RR_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [AW-1:0]    wr_addr,
  input  logic [DW-1:0]    wr_data,
  input  logic             rd_valid,
  output logic             rd_ready,
  input  logic [AW-1:0]    rd_addr,
  output logic [DW-1:0]    rd_data,
  output logic             rd_rvalid,
  output logic             rd_hit,
  input  logic             clr,
  output logic [WORDS-1:0] word_written,
  output logic             ram_wr,
  output logic [AW-1:0]    ram_addr,
  output logic [DW-1:0]    ram_din,
  input  logic [DW-1:0]    ram_dout
);

  localparam logic RR_EN_BIT = (RR_EN != 0) ? 1'b1 : 1'b0;

  grant_t arb_gnt;
  grant_t gnt;

  logic [WORDS-1:0] word_written_q;
  logic [WORDS-1:0] word_written_d;
  logic             rvalid_q;
  logic             rvalid_d;
  logic             hit_q;
  logic             hit_d;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_req (wr_valid),
    .rd_req (rd_valid),
    .rr_en  (RR_EN_BIT),
    .grant  (arb_gnt)
  );

  // No grant is issued while reset is held, so the RAM port stays quiet.
  always_comb begin
    gnt = GNT_NONE;
    if (rst_n) begin
      gnt = arb_gnt;
    end else begin
      gnt = GNT_NONE;
    end
  end

  // Ready strobes and RAM port drive for the granted side; idle reads word 0.
  always_comb begin
    wr_ready = 1'b0;
    rd_ready = 1'b0;
    ram_wr   = 1'b0;
    ram_addr = {AW{1'b0}};
    ram_din  = {DW{1'b0}};
    case (gnt)
      GNT_WR: begin
        wr_ready = 1'b1;
        ram_wr   = 1'b1;
        ram_addr = wr_addr;
        ram_din  = wr_data;
      end
      GNT_RD: begin
        rd_ready = 1'b1;
        ram_addr = rd_addr;
      end
      default: begin
        ram_wr = 1'b0;
      end
    endcase
  end

  // Next written mask (clear before the new write bit) and read pipeline;
  // the hit flag samples the mask as it was before any same-cycle clear.
  always_comb begin
    word_written_d = word_written_q;
    rvalid_d       = 1'b0;
    hit_d          = 1'b0;
    if (clr) begin
      word_written_d = {WORDS{1'b0}};
    end else begin
      word_written_d = word_written_q;
    end
    if (gnt == GNT_WR) begin
      word_written_d = word_written_d | ({{(WORDS-1){1'b0}}, 1'b1} << wr_addr);
    end else begin
      word_written_d = word_written_d;
    end
    if (gnt == GNT_RD) begin
      rvalid_d = 1'b1;
      hit_d    = word_written_q[rd_addr];
    end else begin
      rvalid_d = 1'b0;
      hit_d    = 1'b0;
    end
  end

  // Mask and read-pipeline registers; reset drops any read in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_written_q <= {WORDS{1'b0}};
      rvalid_q       <= 1'b0;
      hit_q          <= 1'b0;
    end else begin
      word_written_q <= word_written_d;
      rvalid_q       <= rvalid_d;
      hit_q          <= hit_d;
    end
  end

  // Read return aligned with the RAM's registered dout; data zeroed when idle.
  always_comb begin
    rd_rvalid    = rvalid_q;
    rd_hit       = hit_q;
    word_written = word_written_q;
    rd_data      = {DW{1'b0}};
    if (rvalid_q) begin
      rd_data = ram_dout;
    end else begin
      rd_data = {DW{1'b0}};
    end
  end

endmodule

// File: tb/tb_ram_port_ctrl.sv
// Directed bench for ram_port_ctrl with a behavioural RAM and a read scoreboard.
module tb_ram_port_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_valid = 1'b0;
  logic [2:0] wr_addr = 3'd0;
  logic [7:0] wr_data = 8'd0;
  logic       rd_valid = 1'b0;
  logic [2:0] rd_addr = 3'd0;
  logic       clr = 1'b0;

  logic       wr_ready, rd_ready, rd_rvalid, rd_hit, ram_wr;
  logic [7:0] rd_data, ram_din, ram_dout, word_written;
  logic [2:0] ram_addr;

  logic       wr_ready0, rd_ready0, rd_rvalid0, rd_hit0, ram_wr0;
  logic [7:0] rd_data0, ram_din0, word_written0;
  logic [2:0] ram_addr0;

  logic [7:0] ram_mem [0:7];

  typedef struct packed {
    logic [7:0] data;
    logic       hit;
  } rd_exp_t;

  rd_exp_t    sb[$];
  logic [7:0] mem_m [0:7];
  logic [7:0] mask_m;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  ram_port_ctrl #(.WORDS(8), .AW(3), .DW(8), .RR_EN(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_rvalid(rd_rvalid), .rd_hit(rd_hit),
    .clr(clr), .word_written(word_written),
    .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // Fixed-priority instance: only its grants are checked.
  ram_port_ctrl #(.WORDS(8), .AW(3), .DW(8), .RR_EN(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready0), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready0), .rd_addr(rd_addr),
    .rd_data(rd_data0), .rd_rvalid(rd_rvalid0), .rd_hit(rd_hit0),
    .clr(clr), .word_written(word_written0),
    .ram_wr(ram_wr0), .ram_addr(ram_addr0), .ram_din(ram_din0), .ram_dout(8'h00)
  );

  // Single-port RAM with registered read.
  always @(posedge clk) begin
    if (ram_wr) ram_mem[ram_addr] <= ram_din;
    ram_dout <= ram_mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: drive, check grants/port, then check the return.
  task automatic step(input logic wv, input logic [2:0] wa, input logic [7:0] wd,
                      input logic rv, input logic [2:0] ra, input logic cl,
                      input logic ewr, input logic erd, input string tag);
    rd_exp_t e;
    @(negedge clk);
    wr_valid = wv; wr_addr = wa; wr_data = wd;
    rd_valid = rv; rd_addr = ra; clr = cl;
    #1;
    check({tag, ".wr_ready"}, 32'(wr_ready), 32'(ewr));
    check({tag, ".rd_ready"}, 32'(rd_ready), 32'(erd));
    check({tag, ".rd_ready_fixed"}, 32'(rd_ready0), 32'(rv));
    check({tag, ".wr_ready_fixed"}, 32'(wr_ready0), 32'(wv & ~rv));
    if (ewr) begin
      check({tag, ".ram_port"}, {15'd0, ram_wr, 5'd0, ram_addr, ram_din}, {15'd0, 1'b1, 5'd0, wa, wd});
    end else if (erd) begin
      check({tag, ".ram_port"}, {15'd0, ram_wr, 5'd0, ram_addr, ram_din}, {15'd0, 1'b0, 5'd0, ra, 8'h00});
    end else begin
      check({tag, ".ram_port"}, {15'd0, ram_wr, 5'd0, ram_addr, ram_din}, 32'd0);
    end
    if (erd) begin
      e.data = mem_m[ra];
      e.hit  = mask_m[ra];
      sb.push_back(e);
    end
    if (cl) mask_m = 8'h00;
    if (ewr) begin
      mem_m[wa]  = wd;
      mask_m[wa] = 1'b1;
    end
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, ".rd_rvalid"}, 32'(rd_rvalid), 32'd1);
      check({tag, ".rd_data"}, 32'(rd_data), 32'(e.data));
      check({tag, ".rd_hit"}, 32'(rd_hit), 32'(e.hit));
    end else begin
      check({tag, ".rd_rvalid_idle"}, 32'(rd_rvalid), 32'd0);
      check({tag, ".rd_data_idle"}, 32'(rd_data), 32'd0);
    end
    check({tag, ".word_written"}, 32'(word_written), 32'(mask_m));
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem_m[i] = 8'h00;
    mask_m = 8'h00;

    // Reset with both requests asserted: nothing may be granted.
    wr_valid = 1'b1; rd_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst.wr_ready", 32'(wr_ready), 32'd0);
    check("rst.rd_ready", 32'(rd_ready), 32'd0);
    check("rst.ram_port", {23'd0, ram_wr, ram_addr, ram_din}, 32'd0);
    check("rst.rd_rvalid", 32'(rd_rvalid), 32'd0);
    check("rst.rd_data_hit", {23'd0, rd_data, rd_hit}, 32'd0);
    check("rst.word_written", 32'(word_written), 32'd0);
    @(negedge clk);
    wr_valid = 1'b0; rd_valid = 1'b0;
    rst_n = 1'b1;

    // Load 0x11..0x88 into addresses 0..7.
    for (int i = 0; i < 8; i++)
      step(1'b1, 3'(i), 8'(8'h11 * (i + 1)), 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, "load");

    // Back-to-back read-back 7..0.
    for (int i = 7; i >= 0; i--)
      step(1'b0, 3'd0, 8'h00, 1'b1, 3'(i), 1'b0, 1'b0, 1'b1, "readback");

    // Contention: round-robin gives RD, WR, RD, WR.
    step(1'b1, 3'd5, 8'hA5, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, "conflict1");
    step(1'b1, 3'd5, 8'hA5, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, "conflict2");
    step(1'b1, 3'd6, 8'hB6, 1'b1, 3'd5, 1'b0, 1'b0, 1'b1, "conflict3");
    step(1'b1, 3'd6, 8'hB6, 1'b1, 3'd5, 1'b0, 1'b1, 1'b0, "conflict4");
    step(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, "idle");

    // Write then read the same address in consecutive cycles.
    step(1'b1, 3'd3, 8'h5A, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, "wr3");
    step(1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1, "rd3");

    // Clear, then a read misses; clear with write leaves one bit.
    step(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, "clr");
    step(1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 1'b0, 1'b0, 1'b1, "rd2_miss");
    step(1'b1, 3'd4, 8'hC4, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, "clr_wr4");
    // A read in the clear cycle sees the pre-clear mask.
    step(1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 1'b1, 1'b0, 1'b1, "clr_rd4");

    // Reset asserted in a read grant cycle.
    @(negedge clk);
    wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 3'd4; clr = 1'b0;
    #1;
    check("midrst.pre_grant", 32'(rd_ready), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst.readies", {30'd0, wr_ready, rd_ready}, 32'd0);
    check("midrst.ram_port", {23'd0, ram_wr, ram_addr, ram_din}, 32'd0);
    check("midrst.rd_out", {22'd0, rd_rvalid, rd_data, rd_hit}, 32'd0);
    check("midrst.word_written", 32'(word_written), 32'd0);
    mask_m = 8'h00;
    @(posedge clk);
    #1;
    check("midrst.rd_rvalid_edge", 32'(rd_rvalid), 32'd0);
    @(negedge clk);
    rd_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst.rd_rvalid_after", 32'(rd_rvalid), 32'd0);
    check("midrst.word_written_after", 32'(word_written), 32'd0);

    // Conflict history restarts: first conflict after reset goes to read.
    step(1'b1, 3'd1, 8'h99, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1, "postrst_conflict");
    step(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, "final_idle");

    check("sb.empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
